// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer placed after uart_rx.
// Optional registered almost_full flow-control hint, enabled by defining
// UART_RX_FIFO_ALMOST_FULL_EN (AF_LEVEL is only meaningful in that build).
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  count
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,
   output logic                    almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Reject illegal configurations at elaboration time.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
      end
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
         $error("uart_rx_fifo: AF_LEVEL must lie in 1..DEPTH");
      end
   endgenerate

   // Storage is deliberately not reset; the pointers define what is valid.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q,  count_d;

   logic empty;
   logic full;
   logic wr_en;
   logic rd_en;

   // Pointer comparison: the extra MSB distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // Handshakes; both are suppressed while reset is asserted.
   assign in_ready  = !full && !rst;
   assign out_valid = !empty;
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready && !rst;

   // First-word-fall-through: the head entry is always on the output.
   assign out_data = mem_q[rd_ptr_q[AW-1:0]];
   assign count    = count_q;

   // Next-state pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Word storage write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_data;
      end
   end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

   logic almost_full_q;
   logic almost_full_d;

   // Look at next-state occupancy so the flag tracks count with no lag.
   always_comb begin
      almost_full_d = (count_d >= AF_THRESH);
   end

   // Registered almost-full flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= almost_full_d;
      end
   end

   assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven directed checks for uart_rx_fifo
// (DEPTH=4, DATA_WIDTH=8, AF_LEVEL=3). Works with and without
// UART_RX_FIFO_ALMOST_FULL_EN defined.
module tb_uart_rx_fifo;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int AF = 3;

   logic          clk;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    count;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   logic          almost_full;
`endif

   uart_rx_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP),
      .AF_LEVEL   (AF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      ,
      .almost_full(almost_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs for one cycle plus the outputs expected during that cycle
   // (i.e. the state left by the previous edge).
   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic [2:0] e_cnt;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_ir;
      logic       e_af;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   vec_no   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic iv, input logic [7:0] id, input logic ordy,
                      input logic [2:0] cnt, input logic ov, input logic [7:0] od,
                      input logic ir, input logic af);
      vec_t v;
      v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_cnt = cnt; v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_af = af;
      vecs.push_back(v);
   endtask

   // Drive one cycle, check mid-cycle, then advance past the next edge.
   task automatic run_vec(input vec_t v);
      rst       = v.rst;
      in_valid  = v.iv;
      in_data   = v.id;
      out_ready = v.ordy;
      #1;
      $display("vec %0d: rst=%0d iv=%0d id=%02h ordy=%0d -> cnt=%0d ov=%0d od=%02h ir=%0d",
               vec_no, v.rst, v.iv, v.id, v.ordy, count, out_valid, out_data, in_ready);
      chk($sformatf("v%0d count", vec_no), 32'(count), 32'(v.e_cnt));
      chk($sformatf("v%0d out_valid", vec_no), 32'(out_valid), 32'(v.e_ov));
      chk($sformatf("v%0d in_ready", vec_no), 32'(in_ready), 32'(v.e_ir));
      if (v.e_ov) begin
         chk($sformatf("v%0d out_data", vec_no), 32'(out_data), 32'(v.e_od));
      end
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk($sformatf("v%0d almost_full", vec_no), 32'(almost_full), 32'(v.e_af));
`endif
      vec_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;

      //  rst iv id     ordy | cnt ov od     ir af
      // Reset: three edges with rst=1 (one before the table, two here).
      add(1, 0, 8'h00, 0,   0, 0, 8'h00, 0, 0);
      add(1, 1, 8'h99, 1,   0, 0, 8'h00, 0, 0);
      add(0, 0, 8'h00, 0,   0, 0, 8'h00, 1, 0);
      // Fill with consumer stalled.
      add(0, 1, 8'h11, 0,   0, 0, 8'h00, 1, 0);
      add(0, 1, 8'h22, 0,   1, 1, 8'h11, 1, 0);
      add(0, 1, 8'h33, 0,   2, 1, 8'h11, 1, 0);
      add(0, 1, 8'h44, 0,   3, 1, 8'h11, 1, 1);
      add(0, 0, 8'h00, 0,   4, 1, 8'h11, 0, 1);
      // Drain in order.
      add(0, 0, 8'h00, 1,   4, 1, 8'h11, 0, 1);
      add(0, 0, 8'h00, 1,   3, 1, 8'h22, 1, 1);
      add(0, 0, 8'h00, 1,   2, 1, 8'h33, 1, 0);
      add(0, 0, 8'h00, 1,   1, 1, 8'h44, 1, 0);
      add(0, 0, 8'h00, 0,   0, 0, 8'h00, 1, 0);
      // Refill to full; almost_full rises with count 2->3.
      add(0, 1, 8'h11, 0,   0, 0, 8'h00, 1, 0);
      add(0, 1, 8'h22, 0,   1, 1, 8'h11, 1, 0);
      add(0, 1, 8'h33, 0,   2, 1, 8'h11, 1, 0);
      add(0, 1, 8'h44, 0,   3, 1, 8'h11, 1, 1);
      // Full plus read: 0x11 pops, 0x55 refused, then accepted next cycle.
      add(0, 1, 8'h55, 1,   4, 1, 8'h11, 0, 1);
      add(0, 1, 8'h55, 0,   3, 1, 8'h22, 1, 1);
      add(0, 0, 8'h00, 0,   4, 1, 8'h22, 0, 1);
      // Drain: 22,33,44,55; almost_full drops at count 2.
      add(0, 0, 8'h00, 1,   4, 1, 8'h22, 0, 1);
      add(0, 0, 8'h00, 1,   3, 1, 8'h33, 1, 1);
      add(0, 0, 8'h00, 1,   2, 1, 8'h44, 1, 0);
      add(0, 0, 8'h00, 1,   1, 1, 8'h55, 1, 0);
      add(0, 0, 8'h00, 0,   0, 0, 8'h00, 1, 0);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      foreach (vecs[i]) run_vec(vecs[i]);

      // Streaming: 20 words in and out back to back, count settles at 1.
      for (int k = 0; k <= 21; k++) begin
         v.rst   = 1'b0;
         v.iv    = (k < 20);
         v.id    = (k < 20) ? 8'(k) : 8'h00;
         v.ordy  = 1'b1;
         v.e_cnt = (k == 0 || k == 21) ? 3'd0 : 3'd1;
         v.e_ov  = (k != 0 && k != 21);
         v.e_od  = (k == 0) ? 8'h00 : 8'(k - 1);
         v.e_ir  = 1'b1;
         v.e_af  = 1'b0;
         run_vec(v);
      end

      // Mid-operation reset discards buffered words; inputs ignored in reset.
      vecs.delete();
      add(0, 1, 8'h01, 0,   0, 0, 8'h00, 1, 0);
      add(0, 1, 8'h02, 0,   1, 1, 8'h01, 1, 0);
      add(0, 1, 8'h03, 0,   2, 1, 8'h01, 1, 0);
      add(1, 1, 8'h77, 1,   3, 1, 8'h01, 0, 1);
      add(0, 1, 8'hA5, 0,   0, 0, 8'h00, 1, 0);
      add(0, 1, 8'hB6, 1,   1, 1, 8'hA5, 1, 0);
      add(0, 0, 8'h00, 1,   1, 1, 8'hB6, 1, 0);
      add(0, 0, 8'h00, 0,   0, 0, 8'h00, 1, 0);
      foreach (vecs[i]) run_vec(vecs[i]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of uart_rx.
- Accepts received words on a valid/ready handshake; its in_ready drives uart_rx.ready.
- Presents buffered words first-word-fall-through to the consumer on a second valid/ready handshake.
- Decouples bursty serial reception from a consumer that may stall for several character times.

Parameters:
- DATA_WIDTH, 8, word width; matches uart_rx DATA_WIDTH.
- DEPTH, 16, number of storage entries; power of two, >= 2.
- AF_LEVEL, DEPTH-2, almost-full threshold in entries; 1..DEPTH. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_data  in  DATA_WIDTH  word from uart_rx.data.
- in_valid  in  1  uart_rx.valid.
- in_ready  out  1  to uart_rx.ready; high when not full and not in reset.
- out_data  out  DATA_WIDTH  oldest stored word.
- out_valid  out  1  high when FIFO not empty.
- out_ready  in  1  consumer accept.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  present only with UART_RX_FIFO_ALMOST_FULL_EN.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, not reset.
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the extra MSB is a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = address bits equal and wrap bits differ.
- Pointers wrap naturally modulo 2*DEPTH.
- Write: on a clk edge with in_valid && in_ready, store in_data at mem[wr_ptr], then wr_ptr+1.
- Read: on a clk edge with out_valid && out_ready, rd_ptr+1.
- in_ready = !full && !rst, combinational.
- out_valid = !empty; out_data = mem[rd_ptr], combinational from registered state (FWFT).
- out_data is don't-care while out_valid=0.
- Latency: a word written at edge N appears on out_data/out_valid after edge N (visible in cycle N+1). No same-cycle pass-through when empty.
- count: registered.
  - +1 on write only; -1 on read only.
  - Unchanged on simultaneous write+read, or on neither.
- Simultaneous events:
  - Empty: read impossible (out_valid=0); write proceeds.
  - Full: in_ready=0, so no write even if a read occurs that cycle. in_ready rises the cycle after the read.
  - Otherwise both proceed and count holds.
- Words are delivered in arrival order with no loss or duplication while the handshake is obeyed.
- Reset (synchronous, also mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0 at the next edge; out_valid=0 from that edge.
  - in_ready=0 during any cycle rst=1.
  - Buffered data is discarded.
  - in_valid/out_ready are ignored while rst=1.
- Upstream stall: when in_ready=0, uart_rx holds or drops the word by its own rules. This block never asserts an error.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - Port almost_full exists and is registered.
  - almost_full = 1 when the next-state count >= AF_LEVEL; reset value 0.
  - Intended as an RTS-style flow-control hint to the remote transmitter.
- Undefined: port and logic absent; AF_LEVEL unused. All other behaviour identical.

Test Plan (DEPTH=4, DATA_WIDTH=8, AF_LEVEL=3):
- Reset: rst=1 for 3 cycles, then release -> count=0, out_valid=0, in_ready=0 during reset, in_ready=1 the first cycle after.
- Fill/drain: write 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, out_valid=1, out_data=0x11. Then out_ready=1 for 4 cycles -> outputs 0x11,0x22,0x33,0x44 in order, then out_valid=0, count=0.
- Full plus read: FIFO full, in_valid=1 (0x55) and out_ready=1 in the same cycle -> 0x11 popped, 0x55 not written, count=3. Next cycle in_ready=1 and 0x55 written, count=4.
- Streaming wrap: in_valid=1 and out_ready=1 continuously for 20 words 0x00..0x13 -> outputs identical, 1-cycle latency, count stays at 1 after the first word, pointers wrap more than twice.
- Mid-operation reset: 3 words stored, rst=1 for 1 cycle -> count=0, out_valid=0. The next written word 0xA5 is the first read out.
- Feature on: count rising 2->3 -> almost_full=1 in the same cycle count=3. A read back to 2 -> almost_full=0. Macro undefined -> port absent; the bench compiles both ways.
